// File: rtl/eda_neigh_queue.sv
// Neighbour push queue: serialises a 3x3 window push mask into neighbour
// addresses and buffers them in a first-word-fall-through FIFO.
module eda_neigh_queue #(
  parameter int M            = 16,
  parameter int N            = 16,
  parameter int WINDOW_WIDTH = 9,
  parameter int ADDR_WIDTH   = $clog2(M * N),
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic [WINDOW_WIDTH-2:0]         push_positions,
  input  logic [ADDR_WIDTH-1:0]           center_addr,
  output logic                            busy,
  output logic                            ovf_err,
  input  logic                            pop,
  output logic                            pop_valid,
  output logic [ADDR_WIDTH-1:0]           pop_addr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            fsm_state
);

  localparam int MW      = WINDOW_WIDTH - 1;
  localparam int KW      = $clog2(MW);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int CTR_POS = MW / 2;

  typedef enum logic {IDLE = 1'b0, SER = 1'b1} state_t;

  // Handshake: an entry leaves the FIFO on a clock edge where pop && pop_valid;
  // pop while pop_valid=0 has no effect. push_positions is a one-cycle pulse.

  state_t                 state, state_next;
  logic [MW-1:0]          pend, pend_next, sel_bit;
  logic [ADDR_WIDTH-1:0]  ctr, nb_addr;
  logic [KW-1:0]          sel_k;
  int                     pos;
  logic                   flush, has_mask, full, pop_fire;
  logic                   write_en, last_wr, accept, ovf_set;
  logic [ADDR_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]          wptr, rptr;

  assign flush     = reset | clear;
  assign has_mask  = |push_positions;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop_valid = (count != '0);
  assign pop_fire  = pop & pop_valid;
  assign pop_addr  = pop_valid ? mem[rptr] : '0;
  assign fsm_state = state;

  // Lowest set bit of the pending mask and the neighbour address it maps to.
  always_comb begin
    sel_k = '0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (pend[i]) sel_k = KW'(i);
    end
    sel_bit   = MW'(1) << sel_k;
    pend_next = pend & ~sel_bit;
    pos       = int'(sel_k);
    if (pos >= CTR_POS) pos = pos + 1;
    nb_addr   = ctr + ADDR_WIDTH'((pos / 3 - 1) * N + (pos % 3) - 1);
  end

  always_ff @(posedge clk) begin
    if (flush) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (has_mask) state_next = SER;
      SER:     if (last_wr && !has_mask) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == SER);
    write_en = busy && (!full || pop_fire);
    last_wr  = write_en && (pend_next == '0);
    accept   = has_mask && ((state == IDLE) || last_wr);
    ovf_set  = has_mask && busy && !last_wr;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      pend    <= '0;
      ctr     <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (accept) begin
        pend <= push_positions;
        ctr  <= center_addr;
      end else if (write_en) begin
        pend <= pend_next;
      end
      if (ovf_set) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (write_en) wptr <= wptr + PW'(1);
      if (pop_fire) rptr <= rptr + PW'(1);
      if (write_en && !pop_fire)      count <= count + CW'(1);
      else if (!write_en && pop_fire) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (write_en && !flush) mem[wptr] <= nb_addr;
  end

endmodule

// File: tb/tb_eda_neigh_queue.sv
// Randomised and directed bench for eda_neigh_queue against a queue-level
// model of the pending neighbour list and the FIFO contents.
module tb_eda_neigh_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset, clear, pop;
  logic [7:0]    push_positions;
  logic [AW-1:0] center_addr;
  logic          busy, ovf_err, pop_valid, fsm_state;
  logic [AW-1:0] pop_addr;
  logic [2:0]    count;

  int vectors     = 0;
  int miscompares = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] pend_q[$];
  bit            m_ovf;

  eda_neigh_queue #(.M(16), .N(16), .WINDOW_WIDTH(9), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear), .push_positions(push_positions),
    .center_addr(center_addr), .busy(busy), .ovf_err(ovf_err), .pop(pop),
    .pop_valid(pop_valid), .pop_addr(pop_addr), .count(count), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic [7:0] m, input logic [AW-1:0] c,
                      input logic p, input logic cl, input logic rs);
    bit busy_b, pf, last, can_wr;
    int size_pre, pos, dr, dc;
    push_positions = m;
    center_addr    = c;
    pop            = p;
    clear          = cl;
    reset          = rs;
    @(posedge clk);
    if (rs || cl) begin
      exp_q.delete();
      pend_q.delete();
      m_ovf = 1'b0;
    end else begin
      busy_b   = (pend_q.size() > 0);
      size_pre = exp_q.size();
      pf       = p && (size_pre > 0);
      last     = 1'b0;
      can_wr   = busy_b && ((size_pre < DEPTH) || pf);
      if (pf) void'(exp_q.pop_front());
      if (can_wr) begin
        exp_q.push_back(pend_q.pop_front());
        last = (pend_q.size() == 0);
      end
      if (m != 8'h00) begin
        if (!busy_b || last) begin
          for (int k = 0; k < 8; k++) begin
            if (m[k]) begin
              pos = (k < 4) ? k : k + 1;
              dr  = pos / 3 - 1;
              dc  = pos % 3 - 1;
              pend_q.push_back(AW'(int'(c) + dr * 16 + dc));
            end
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    #1;
    check("busy", 32'(busy), 32'(pend_q.size() > 0));
    check("count", 32'(count), 32'(exp_q.size()));
    check("pop_valid", 32'(pop_valid), 32'(exp_q.size() > 0));
    check("ovf_err", 32'(ovf_err), 32'(m_ovf));
    if (exp_q.size() > 0) check("pop_addr", 32'(pop_addr), 32'(exp_q[0]));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (pend_q.size() > 0 || exp_q.size() > 0); i++)
      step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("drain_empty", 32'(count), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] tp2_exp[4];
    logic [7:0]    rm;
    tp2_exp = '{8'h21, 8'h23, 8'h30, 8'h50};
    m_ovf   = 1'b0;

    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rst_pop_addr", 32'(pop_addr), 32'd0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Two-bit mask, then drain through pop.
    step(8'h81, 8'h22, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("tp1_head", 32'(pop_addr), 32'h11);
    check("tp1_count", 32'(count), 32'd2);
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("tp1_head2", 32'(pop_addr), 32'h33);
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("tp1_empty", 32'(pop_valid), 32'd0);

    // Back-to-back capture on the last-write cycle.
    step(8'h18, 8'h22, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h42, 8'h40, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("tp2_ovf", 32'(ovf_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("tp2_order", 32'(pop_addr), 32'(tp2_exp[i]));
      step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    // Full FIFO stalls the serialiser; push-with-pop keeps count.
    step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    step(8'hFF, 8'h55, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("tp3_full", 32'(count), 32'd4);
    check("tp3_busy", 32'(busy), 32'd1);
    check("tp3_head", 32'(pop_addr), 32'h44);
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    check("tp3_count_hold", 32'(count), 32'd4);
    check("tp3_head2", 32'(pop_addr), 32'h45);
    drain();

    // Overlapping mask dropped; sticky error until clear.
    step(8'hFF, 8'h10, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h01, 8'h77, 1'b1, 1'b0, 1'b0);
    check("tp4_ovf", 32'(ovf_err), 32'd1);
    drain();
    check("tp4_ovf_sticky", 32'(ovf_err), 32'd1);
    step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    check("tp4_ovf_clr", 32'(ovf_err), 32'd0);
    check("tp4_busy_clr", 32'(busy), 32'd0);

    // Reset during the third write.
    step(8'hFF, 8'h80, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check("tp5_busy", 32'(busy), 32'd0);
    check("tp5_valid", 32'(pop_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("tp5_count", 32'(count), 32'd0);

    // Pop on empty is ignored.
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h01, 8'h33, 1'b0, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("tp6_head", 32'(pop_addr), 32'h22);
    drain();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rm = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      step(rm, AW'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 299) == 0), ($urandom_range(0, 499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
